// File: rtl/hog_stream_pkg.sv
// Shared FSM encoding and sizing helpers for the HOG multi-window serializer.
package hog_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } ser_state_e;

  // ceil(log2(n)) but never below one bit, so single-entry fields stay legal
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Integer ceiling division, used for the number of bus beats per window
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping from CHANNELS-1 back to 0. Also returns the binary grant index.
module rr_arbiter
  import hog_stream_pkg::*;
#(
  parameter int  CHANNELS = 15,
  localparam int CH_W     = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [CH_W-1:0]     grant_idx
);

  logic found_s;
  int   idx_s;

  // Scan the channels starting at ptr and grant the first one requesting
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx_s = (int'(ptr) + i) % CHANNELS;
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = CH_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/multi_window_serializer.sv
// Multi-channel HOG window serializer: arbitrates between pyramid-level
// channels and streams one accepted window as an optional header beat
// followed by LSB-first data beats on a ready/valid bus.
module multi_window_serializer
  import hog_stream_pkg::*;
#(
  parameter int  WINDOW_WIDTH = 1152,
  parameter int  BUS_WIDTH    = 128,
  parameter int  CHANNELS     = 15,
  parameter int  META_WIDTH   = 4,
  parameter int  HEADER_EN    = 1,
  localparam int CH_W         = clog2_min1(CHANNELS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS-1:0]              window_valid,
  output logic [CHANNELS-1:0]              window_ready,
  input  logic [CHANNELS*WINDOW_WIDTH-1:0] window,
  input  logic [CHANNELS*META_WIDTH-1:0]   metadata,
  output logic [BUS_WIDTH-1:0]             stream,
  output logic                             stream_valid,
  input  logic                             stream_ready,
  output logic                             stream_last,
  output logic [CH_W-1:0]                  stream_chan
);

  localparam int               BEATS     = ceil_div(WINDOW_WIDTH, BUS_WIDTH);
  localparam int               PAD_W     = BEATS * BUS_WIDTH;
  localparam int               CNT_W     = clog2_min1(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic             ONE_BEAT  = (BEATS == 1) ? 1'b1 : 1'b0;

  ser_state_e         state_r;
  logic [CH_W-1:0]    rr_ptr_r;
  logic [CNT_W-1:0]   beat_r;
  logic [PAD_W-1:0]   win_r;

  logic [CHANNELS-1:0]     grant_s;
  logic [CH_W-1:0]         grant_idx_s;
  logic                    accept_s;
  logic [WINDOW_WIDTH-1:0] win_sel_s;
  logic [META_WIDTH-1:0]   meta_sel_s;
  logic [PAD_W-1:0]        win_pad_s;
  logic [BUS_WIDTH-1:0]    header_s;
  logic [CNT_W-1:0]        next_beat_s;
  logic [BUS_WIDTH-1:0]    next_data_s;
  logic [CH_W-1:0]         rr_next_s;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req       (window_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Offer the arbiter's grant only while idle and out of reset
  always_comb begin
    if ((state_r == ST_IDLE) && rst_n) begin
      window_ready = grant_s;
    end else begin
      window_ready = '0;
    end
  end

  assign accept_s = |(window_valid & window_ready);

  // Select the granted payload and precompute header, next beat and next pointer
  always_comb begin
    win_sel_s  = window[int'(grant_idx_s) * WINDOW_WIDTH +: WINDOW_WIDTH];
    meta_sel_s = metadata[int'(grant_idx_s) * META_WIDTH +: META_WIDTH];
    win_pad_s  = PAD_W'(win_sel_s);
    header_s   = '0;
    header_s[META_WIDTH-1:0]     = meta_sel_s;
    header_s[META_WIDTH +: CH_W] = grant_idx_s;
    next_beat_s = beat_r + CNT_W'(1);
    next_data_s = BUS_WIDTH'(win_r >> (int'(next_beat_s) * BUS_WIDTH));
    if (int'(grant_idx_s) == CHANNELS - 1) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + CH_W'(1);
    end
  end

  // Serializer FSM, beat counter and registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      beat_r       <= '0;
      win_r        <= '0;
      stream       <= '0;
      stream_valid <= 1'b0;
      stream_last  <= 1'b0;
      stream_chan  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            win_r        <= win_pad_s;
            rr_ptr_r     <= rr_next_s;
            beat_r       <= '0;
            stream_valid <= 1'b1;
            stream_chan  <= grant_idx_s;
            if (HEADER_EN != 0) begin
              state_r     <= ST_HEADER;
              stream      <= header_s;
              stream_last <= 1'b0;
            end else begin
              state_r     <= ST_DATA;
              stream      <= win_pad_s[BUS_WIDTH-1:0];
              stream_last <= ONE_BEAT;
            end
          end
        end
        ST_HEADER: begin
          if (stream_ready) begin
            state_r     <= ST_DATA;
            stream      <= win_r[BUS_WIDTH-1:0];
            stream_last <= ONE_BEAT;
            beat_r      <= '0;
          end
        end
        ST_DATA: begin
          if (stream_ready) begin
            if (beat_r == LAST_BEAT) begin
              state_r      <= ST_IDLE;
              stream_valid <= 1'b0;
              stream_last  <= 1'b0;
              stream       <= '0;
              beat_r       <= '0;
            end else begin
              beat_r      <= next_beat_s;
              stream      <= next_data_s;
              stream_last <= (next_beat_s == LAST_BEAT);
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          stream_valid <= 1'b0;
          stream_last  <= 1'b0;
          beat_r       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_window_serializer.sv
// Self-checking bench for multi_window_serializer: hand sequences, an arbitration
// table and randomized traffic checked against a queue-based beat model.
module tb_multi_window_serializer;

  localparam int CH  = 15;
  localparam int WW  = 1152;
  localparam int BW  = 128;
  localparam int MW  = 4;
  localparam int CW  = 4;
  localparam int NB  = (WW + BW - 1) / BW;
  localparam int WW2 = 200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     window_valid;
  logic [CH-1:0]     window_ready;
  logic [CH*WW-1:0]  window;
  logic [CH*MW-1:0]  metadata;
  logic [BW-1:0]     stream;
  logic              stream_valid;
  logic              stream_ready;
  logic              stream_last;
  logic [CW-1:0]     stream_chan;

  logic [CH-1:0]     window_valid2;
  logic [CH-1:0]     window_ready2;
  logic [CH*WW2-1:0] window2;
  logic [CH*MW-1:0]  metadata2;
  logic [BW-1:0]     stream2;
  logic              stream_valid2;
  logic              stream_ready2;
  logic              stream_last2;
  logic [CW-1:0]     stream_chan2;

  logic [WW-1:0] win_a  [CH];
  logic [MW-1:0] meta_a [CH];

  always #5 clk = ~clk;

  for (genvar i = 0; i < CH; i++) begin : g_pack
    assign window[i*WW +: WW]   = win_a[i];
    assign metadata[i*MW +: MW] = meta_a[i];
  end

  multi_window_serializer dut (
    .clk (clk), .rst_n (rst_n),
    .window_valid (window_valid), .window_ready (window_ready),
    .window (window), .metadata (metadata),
    .stream (stream), .stream_valid (stream_valid), .stream_ready (stream_ready),
    .stream_last (stream_last), .stream_chan (stream_chan)
  );

  multi_window_serializer #(.WINDOW_WIDTH(WW2), .BUS_WIDTH(BW), .CHANNELS(CH),
                            .META_WIDTH(MW), .HEADER_EN(0)) dut2 (
    .clk (clk), .rst_n (rst_n),
    .window_valid (window_valid2), .window_ready (window_ready2),
    .window (window2), .metadata (metadata2),
    .stream (stream2), .stream_valid (stream_valid2), .stream_ready (stream_ready2),
    .stream_last (stream_last2), .stream_chan (stream_chan2)
  );

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic [CW-1:0] chan;
  } beat_t;

  typedef struct {
    logic [CH-1:0] valid;
    logic [CH-1:0] exp_ready;
  } arb_vec_t;

  beat_t exp_q[$];
  beat_t prev_beat;
  bit    stalled_prev;
  int    rr;
  int    last_acc;
  int    wait_cnt [CH];
  int    errors;
  int    checks;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] rand_win();
    logic [WW-1:0] w;
    for (int j = 0; j < WW / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  // First valid channel at or after ptr, wrapping; -1 when none valid
  function automatic int model_grant(input logic [CH-1:0] v, input int ptr);
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (ptr + i) % CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic push_window(input int g);
    beat_t b;
    logic [WW-1:0] w;
    w = win_a[g];
    b.data = (BW'(g) << MW) | BW'(meta_a[g]);
    b.last = 1'b0;
    b.chan = CW'(g);
    exp_q.push_back(b);
    for (int k = 0; k < NB; k++) begin
      b.data = BW'(w >> (k * BW));
      b.last = (k == NB - 1);
      b.chan = CW'(g);
      exp_q.push_back(b);
    end
  endtask

  // Called just after inputs are set on a falling edge: check and advance the model
  task automatic step();
    bit idle;
    int g;
    logic [CH-1:0] exp_rdy;
    #1;
    idle     = (exp_q.size() == 0);
    last_acc = -1;
    if (stalled_prev)
      chk("stall_hold", {stream, stream_last, stream_chan},
          {prev_beat.data, prev_beat.last, prev_beat.chan});
    chk("stream_valid", stream_valid, !idle);
    if (stream_valid && !idle) begin
      chk("beat_data", stream, exp_q[0].data);
      chk("beat_last", stream_last, exp_q[0].last);
      chk("beat_chan", stream_chan, exp_q[0].chan);
    end
    if (!rst_n) begin
      chk("ready_in_reset", window_ready, {CH{1'b0}});
      exp_q.delete();
      rr = 0;
      stalled_prev = 1'b0;
      for (int c = 0; c < CH; c++) wait_cnt[c] = 0;
    end else begin
      if (stream_valid && stream_ready && !idle) void'(exp_q.pop_front());
      stalled_prev   = stream_valid && !stream_ready;
      prev_beat.data = stream;
      prev_beat.last = stream_last;
      prev_beat.chan = stream_chan;
      g = idle ? model_grant(window_valid, rr) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("window_ready", window_ready, exp_rdy);
      for (int c = 0; c < CH; c++) if (!window_valid[c]) wait_cnt[c] = 0;
      if (g >= 0) begin
        chk("no_starvation", (wait_cnt[g] < CH), 1'b1);
        for (int c = 0; c < CH; c++) if (c != g && window_valid[c]) wait_cnt[c]++;
        wait_cnt[g] = 0;
        push_window(g);
        rr = (g + 1) % CH;
        last_acc = g;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      window_valid = '0;
      stream_ready = 1'b1;
      step();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0; window_valid = '0; step();
    @(negedge clk); step();
    @(negedge clk); rst_n = 1'b1; step();
  endtask

  initial begin
    arb_vec_t tbl [6];
    logic [223:0] w2;
    int n;
    int vcnt;

    tbl[0] = '{15'h4021, 15'h0001};
    tbl[1] = '{15'h4020, 15'h0020};
    tbl[2] = '{15'h4000, 15'h4000};
    tbl[3] = '{15'h0001, 15'h0001};
    tbl[4] = '{15'h4001, 15'h4000};
    tbl[5] = '{15'h0001, 15'h0001};

    errors = 0; checks = 0; rr = 0; stalled_prev = 1'b0; last_acc = -1;
    for (int c = 0; c < CH; c++) begin
      win_a[c] = rand_win(); meta_a[c] = MW'(c); wait_cnt[c] = 0;
    end
    rst_n = 1'b0; window_valid = {CH{1'b1}}; stream_ready = 1'b0;
    window_valid2 = '0; window2 = '0; metadata2 = '0; stream_ready2 = 1'b0;

    // Reset state, with all channels requesting to prove ready is held low
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", stream_valid, 1'b0);
    chk("rst_last", stream_last, 1'b0);
    chk("rst_stream", stream, {BW{1'b0}});
    chk("rst_chan", stream_chan, {CW{1'b0}});
    chk("rst_ready", window_ready, {CH{1'b0}});
    chk("rst_valid2", stream_valid2, 1'b0);
    @(negedge clk); window_valid = '0; rst_n = 1'b1; step();

    // 200-bit window, no header: two beats, upper part of the last beat zero
    for (int j = 0; j < 7; j++) w2[j*32 +: 32] = $urandom;
    @(negedge clk); window2[WW2-1:0] = w2[WW2-1:0]; window_valid2 = 15'h0001;
    stream_ready2 = 1'b1; step();
    chk("w200_ready", window_ready2, 15'h0001);
    @(negedge clk); window_valid2 = '0; step();
    chk("w200_valid1", stream_valid2, 1'b1);
    chk("w200_beat1", stream2, w2[127:0]);
    chk("w200_last1", stream_last2, 1'b0);
    @(negedge clk); step();
    chk("w200_valid2", stream_valid2, 1'b1);
    chk("w200_beat2", stream2[71:0], w2[199:128]);
    chk("w200_pad", stream2[127:72], 56'h0);
    chk("w200_last2", stream_last2, 1'b1);
    chk("w200_chan", stream_chan2, 4'd0);
    @(negedge clk); step();
    chk("w200_idle", stream_valid2, 1'b0);

    // Single window on channel 3 with metadata A
    meta_a[3] = 4'hA; win_a[3] = rand_win();
    @(negedge clk); window_valid = 15'h0008; stream_ready = 1'b1; step();
    chk("ch3_grant", window_ready, 15'h0008);
    for (int k = 0; k < NB + 1; k++) begin
      @(negedge clk); window_valid = '0; step();
      chk("ch3_valid", stream_valid, 1'b1);
      chk("ch3_beat", stream, (k == 0) ? 128'h3A : BW'(win_a[3] >> ((k - 1) * BW)));
      chk("ch3_last", stream_last, (k == NB));
      chk("ch3_chan", stream_chan, 4'd3);
    end
    drain();

    // Arbitration order from a known pointer
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drain();
      @(negedge clk); window_valid = tbl[i].valid; stream_ready = 1'b1; step();
      chk("arb_grant", window_ready, tbl[i].exp_ready);
    end
    drain();

    // Alternating stream_ready: 10 beats take 20 valid cycles
    @(negedge clk); window_valid = 15'h0040; stream_ready = 1'b0; step();
    chk("tog_grant", window_ready, 15'h0040);
    n = 0; vcnt = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk); window_valid = '0; stream_ready = ((n % 2) == 1); step();
      if (stream_valid) vcnt++;
      n++;
    end
    chk("tog_cycles", vcnt, 20);

    // Reset in the middle of data beat 4
    @(negedge clk); window_valid = 15'h0004; stream_ready = 1'b1; step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); window_valid = '0; step();
    end
    @(negedge clk); rst_n = 1'b0; window_valid = 15'h0081; step();
    chk("mid_beat4", stream, BW'(win_a[2] >> (3 * BW)));
    @(negedge clk); step();
    chk("mid_rst_valid", stream_valid, 1'b0);
    chk("mid_rst_ready", window_ready, {CH{1'b0}});
    @(negedge clk); rst_n = 1'b1; step();
    chk("mid_rel_grant", window_ready, 15'h0001);
    drain();

    // Randomized traffic against the beat model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (last_acc >= 0) window_valid[last_acc] = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (!window_valid[c] && $urandom_range(0, 7) == 0) begin
          win_a[c] = rand_win();
          meta_a[c] = MW'($urandom);
          window_valid[c] = 1'b1;
        end
      end
      stream_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_window_serializer.md
MULTI_WINDOW_SERIALIZER -- requirements
Module: multi_window_serializer

Interface
REQ-001 SHALL have parameter WINDOW_WIDTH, default 1152: bits per HOG detection window.
REQ-002 SHALL have parameter BUS_WIDTH, default 128: output stream beat width.
REQ-003 SHALL have parameter CHANNELS, default 15: number of pyramid-level input channels.
REQ-004 SHALL have parameter META_WIDTH, default 4: per-channel metadata width.
REQ-005 SHALL have parameter HEADER_EN, default 1: 1 = prepend one header beat per window; 0 = data beats only.
REQ-006 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port window_valid, input, CHANNELS: per-channel window available.
REQ-009 SHALL have port window_ready, output, CHANNELS: per-channel window accepted.
REQ-010 SHALL have port window, input, CHANNELS*WINDOW_WIDTH: channel i occupies bits [i*WINDOW_WIDTH +: WINDOW_WIDTH].
REQ-011 SHALL have port metadata, input, CHANNELS*META_WIDTH: channel i occupies bits [i*META_WIDTH +: META_WIDTH].
REQ-012 SHALL have port stream, output, BUS_WIDTH: output beat data.
REQ-013 SHALL have port stream_valid, output, 1: beat valid.
REQ-014 SHALL have port stream_ready, input, 1: downstream accepts beat.
REQ-015 SHALL have port stream_last, output, 1: final beat of a window.
REQ-016 SHALL have port stream_chan, output, CH_W=clog2(CHANNELS): source channel of the current beat.

Function
REQ-017 SHALL define BEATS = ceil(WINDOW_WIDTH/BUS_WIDTH) data beats per window (9 at defaults); total beats per window = BEATS + HEADER_EN.
REQ-018 SHALL implement FSM states IDLE, HEADER, DATA; IDLE->HEADER (HEADER_EN=1) or IDLE->DATA (HEADER_EN=0) on acceptance; HEADER->DATA on header handshake; DATA->IDLE on last-beat handshake.
REQ-019 In IDLE, window_ready SHALL be one-hot (or zero) combinationally selecting the first valid channel at or after rr_ptr, wrapping CHANNELS-1 -> 0; window_ready SHALL be zero in all other states.
REQ-020 On acceptance (window_valid[g] & window_ready[g]), SHALL register window[g], metadata[g] and g, and set rr_ptr = g+1 mod CHANNELS.
REQ-021 stream_valid SHALL rise the cycle after acceptance; latency acceptance->first beat = 1 cycle.
REQ-022 Header beat SHALL be {zero padding, g (CH_W bits), metadata (META_WIDTH bits)} with metadata in the LSBs.
REQ-023 Data beats SHALL be sent LSB-first: beat k carries window bits [k*BUS_WIDTH +: BUS_WIDTH]; bits past WINDOW_WIDTH in the final beat SHALL be zero.
REQ-024 stream_last SHALL be 1 only on data beat BEATS-1; stream_chan SHALL equal g on every beat of the window.
REQ-025 While stream_valid=1 and stream_ready=0, stream, stream_last and stream_chan SHALL hold stable; the beat counter SHALL advance only on a handshake.
REQ-026 After the last-beat handshake, the FSM SHALL spend exactly one IDLE cycle before the next acceptance; peak throughput = 1 window per BEATS+HEADER_EN+1 cycles.
REQ-027 Windows arriving during HEADER/DATA SHALL wait (window_ready=0); no channel SHALL be starved: each pending channel is granted within CHANNELS windows.

Reset
REQ-028 With rst_n=0 at a clk edge: state=IDLE, rr_ptr=0, beat counter=0, stream_valid=0, stream_last=0, stream=0, stream_chan=0, window_ready=0.
REQ-029 Reset mid-window SHALL drop the in-flight window without emitting further beats; stream_valid SHALL be 0 in the first cycle after reset.

Structure
REQ-030 SHALL place the FSM state encoding and the clog2-based CH_W/BEATS computation in shared package hog_stream_pkg.
REQ-031 SHALL use one sub-module, rr_arbiter (parametrised by CHANNELS), producing the one-hot grant from window_valid and rr_ptr.

Verification
REQ-032 Single window, channel 3, metadata 4'hA, stream_ready=1 -> header 128'h3A (ch 3 at bits [7:4], meta at [3:0]), then 9 data beats, stream_last only on beat 9, stream_chan=3 throughout.
REQ-033 Channels 0, 5 and 14 valid simultaneously, rr_ptr=0 -> grant order 0, 5, 14; then with rr_ptr=1 and channels 0 and 14 valid -> 14 before 0.
REQ-034 stream_ready toggled 1/0 each cycle -> stream stable during stall cycles; 10 beats complete in 20 cycles; data matches input.
REQ-035 WINDOW_WIDTH=200, BUS_WIDTH=128, HEADER_EN=0 -> 2 beats; beat 2 bits [127:72] = 0.
REQ-036 rst_n driven low during data beat 4 -> next cycle stream_valid=0, window_ready=0; after release, channel 0 is granted first.
